// File: rtl/sdiv_seq_if.sv
// Handshake bundle for the sequential signed divider: start strobe, operands and result.
interface sdiv_seq_if #(
  parameter int WIDTH = 16
);
  logic             go;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic             rdy;

  modport master (
    output go,
    output dividend,
    output divisor,
    input  quotient,
    input  rdy
  );

  modport slave (
    input  go,
    input  dividend,
    input  divisor,
    output quotient,
    output rdy
  );
endinterface

// File: rtl/sdiv_seq.sv
// Sequential signed divider: restoring division on magnitudes, sign applied at the end,
// quotient truncated toward zero with saturation for divide-by-zero and MIN/-1.
//
// state | meaning
// IDLE  | waiting for go; rdy holds its last value
// LOAD  | register magnitudes, result sign and special-case flags
// DIV   | WIDTH restoring iterations, one quotient bit per cycle, MSB first
// DONE  | write sign-corrected quotient, set rdy
module sdiv_seq #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  sdiv_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONE = '1;
  localparam logic [WIDTH-1:0] S_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] S_MAX   = {1'b0, {(WIDTH-1){1'b1}}};

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] mag_d;
  logic [WIDTH-1:0] nq;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;
  logic             neg_res;
  logic             neg_a;
  logic             div0;
  logic             ovf;
  logic [WIDTH-1:0] q_reg;
  logic             rdy_reg;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] result;

  // Unsigned WIDTH-bit magnitude; the most negative value maps to 2^(WIDTH-1) without overflow.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + ONE) : v;
  endfunction

  // nq shifts the dividend magnitude out at the top while quotient bits enter at the bottom.
  assign rem_sh = {rem[WIDTH-1:0], nq[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, mag_d};

  always_comb begin
    result = nq;
    if (div0)
      result = neg_a ? S_MIN : S_MAX;
    else if (ovf)
      result = S_MAX;
    else if (neg_res)
      result = ~nq + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      mag_d   <= '0;
      nq      <= '0;
      rem     <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      neg_a   <= 1'b0;
      div0    <= 1'b0;
      ovf     <= 1'b0;
      q_reg   <= '0;
      rdy_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.go) begin
            a_reg   <= bus.dividend;
            b_reg   <= bus.divisor;
            rdy_reg <= 1'b0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          nq      <= mag(a_reg);
          mag_d   <= mag(b_reg);
          rem     <= '0;
          neg_res <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
          neg_a   <= a_reg[WIDTH-1];
          div0    <= (b_reg == '0);
          ovf     <= (a_reg == S_MIN) && (b_reg == ALL_ONE);
          cnt     <= CW'(WIDTH - 1);
          state   <= DIV;
        end
        DIV: begin
          rem <= diff[WIDTH] ? rem_sh : diff;
          nq  <= {nq[WIDTH-2:0], ~diff[WIDTH]};
          if (cnt == '0)
            state <= DONE;
          else
            cnt <= cnt - 1'b1;
        end
        DONE: begin
          q_reg   <= result;
          rdy_reg <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.quotient = q_reg;
  assign bus.rdy      = rdy_reg;

endmodule

// File: tb/tb_sdiv_seq.sv
// Directed bench for sdiv_seq with a cycle-level behavioural model checked every cycle.
module tb_sdiv_seq;

  localparam int W       = 16;
  localparam int LATENCY = W + 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b0;

  logic [W-1:0] m_q    = '0;
  logic         m_rdy  = 1'b0;
  logic [W-1:0] m_pend = '0;
  int           m_busy = 0;

  sdiv_seq_if #(.WIDTH(W)) bus ();

  sdiv_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: truncating integer division with the saturation rules.
  function automatic int model_div(input int a, input int b);
    int r;
    if (b == 0) return (a >= 0) ? 32767 : -32768;
    r = a / b;
    if (r > 32767) r = 32767;
    return r;
  endfunction

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic run_div(input int a, input int b, input int exp, input string name);
    int lat;
    check_val({name, " model"}, model_div(a, b), exp);
    @(negedge clk);
    bus.go       = 1'b1;
    bus.dividend = W'(a);
    bus.divisor  = W'(b);
    @(negedge clk);
    bus.go = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.rdy === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: rdy never rose", name);
    end else begin
      check_val({name, " latency"}, lat, LATENCY);
      check_val({name, " quotient"}, int'($signed(bus.quotient)), exp);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.go       = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    fork
      forever begin
        @(posedge clk);
        if (rst) begin
          m_q = '0; m_rdy = 1'b0; m_busy = 0;
        end else if (m_busy > 0) begin
          m_busy--;
          if (m_busy == 0) begin
            m_q   = m_pend;
            m_rdy = 1'b1;
          end
        end else if (bus.go === 1'b1) begin
          m_pend = W'(model_div(int'($signed(bus.dividend)), int'($signed(bus.divisor))));
          m_busy = LATENCY;
          m_rdy  = 1'b0;
        end
      end
      forever begin
        @(negedge clk);
        if (chk_en) begin
          checks++;
          if (bus.rdy !== m_rdy) begin
            errors++;
            $display("FAIL cycle rdy @%0t: got %b expected %b", $time, bus.rdy, m_rdy);
          end
          checks++;
          if (bus.quotient !== m_q) begin
            errors++;
            $display("FAIL cycle quotient @%0t: got %0d expected %0d", $time,
                     $signed(bus.quotient), $signed(m_q));
          end
        end
      end
    join_none

    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("reset quotient", int'($signed(bus.quotient)), 0);
    check_val("reset rdy", int'(bus.rdy), 0);
    repeat (3) @(negedge clk);
    check_val("idle rdy low", int'(bus.rdy), 0);

    run_div(25, 5, 5, "25/5");
    repeat (5) @(negedge clk);
    check_val("sticky rdy", int'(bus.rdy), 1);
    check_val("sticky quotient", int'($signed(bus.quotient)), 5);

    run_div(-100, 10, -10, "-100/10");
    run_div(64, -32, -2, "64/-32");
    run_div(-30, -10, 3, "-30/-10");
    run_div(-7, 2, -3, "-7/2");
    run_div(7, -2, -3, "7/-2");
    run_div(32767, 1, 32767, "32767/1");
    run_div(-32768, 1, -32768, "-32768/1");
    run_div(-32768, -1, 32767, "-32768/-1");
    run_div(123, 0, 32767, "123/0");
    run_div(-5, 0, -32768, "-5/0");
    run_div(0, 0, 32767, "0/0");
    run_div(0, 5, 0, "0/5");

    // go pulsed mid-computation and operands changed after capture
    @(negedge clk);
    bus.go = 1'b1; bus.dividend = W'(1000); bus.divisor = W'(7);
    @(negedge clk);
    bus.go = 1'b0; bus.dividend = W'(3); bus.divisor = W'(3);
    repeat (5) @(negedge clk);
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    repeat (LATENCY) @(negedge clk);
    check_val("busy go ignored rdy", int'(bus.rdy), 1);
    check_val("busy go ignored quotient", int'($signed(bus.quotient)), 142);

    // go held high: one division, then another once back in IDLE
    @(negedge clk);
    bus.go = 1'b1; bus.dividend = W'(9); bus.divisor = W'(3);
    repeat (20) @(negedge clk);
    bus.go = 1'b0;
    repeat (25) @(negedge clk);
    check_val("held go quotient", int'($signed(bus.quotient)), 3);
    check_val("held go rdy", int'(bus.rdy), 1);

    // reset in the middle of DIV aborts with no later result
    @(negedge clk);
    bus.go = 1'b1; bus.dividend = W'(50); bus.divisor = W'(5);
    @(negedge clk);
    bus.go = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check_val("abort rdy", int'(bus.rdy), 0);
    check_val("abort quotient", int'($signed(bus.quotient)), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
